i2c_target: RTL
===============

# i2c_target

Synthesizable I2C responder (target) for the IR repositioning design; it is the opposite end of the bus from the `i2c` initiator. It oversamples SCL/SDA on `ref_clk`, detects START/STOP, and matches a 7-bit address. It then serves a 16x8 register file: byte writes through an auto-incrementing pointer, and sequential reads. It is used to loop back and verify the initiator in simulation and on hardware before the real camera is attached.

## Interface
Parameters:
- `ADDR`, 7'h58: 7-bit target address.
- `RESET_FILL`, 8'h00: value of every register-file entry after reset.

Ports:
- `ref_clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `scl_in`  in  1  raw SCL pin level. Asynchronous to `ref_clk`.
- `sda_in`  in  1  raw SDA pin level. Asynchronous to `ref_clk`.
- `sda_oe`  out  1  1 = pull SDA low. 0 = release (pad is open-drain, pulled up).
- `wr_valid`  out  1  one-cycle pulse when a data byte is committed to the register file.
- `wr_addr`  out  4  register index of the committed byte.
- `wr_data`  out  8  committed byte.
- `busy`  out  1  high from an accepted address match until STOP or reset.
- `dbg_addr`  in  4  debug read index.
- `dbg_data`  out  8  register file at `dbg_addr`. Combinational.

## Operation
- **Input sampling.** `scl_in` and `sda_in` each pass through a 2-flop synchronizer, then a registered previous-value copy for edge detection.
- **START/STOP detection.** START = synced SDA 1->0 while synced SCL = 1. STOP = synced SDA 0->1 while synced SCL = 1.
- **Bit timing.** Bits are sampled on the synced SCL rising edge. `sda_oe` changes only on the synced SCL falling edge.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, WAIT_STOP.
- **IDLE.** START -> ADDR with the bit counter cleared.
- **ADDR.** Shift 8 bits MSB first.
  - Upper 7 bits == `ADDR`: go to ADDR_ACK and set `busy`.
  - Otherwise: go to WAIT_STOP with `sda_oe` = 0 (no ACK).
- **ADDR_ACK.** Drive `sda_oe` = 1 from the next SCL fall to the following SCL fall. Then:
  - R/W = 0: go to PTR.
  - R/W = 1: go to RDATA, load `reg[ptr]`, and drive its MSB on that same fall.
- **PTR.** Shift 8 bits; `ptr` <= byte[3:0] (upper bits ignored). ACK as above, then go to WDATA.
- **WDATA.** Shift 8 bits. On the 8th rising edge:
  - `reg[ptr]` <= byte.
  - `wr_valid` = 1 for one cycle, with `wr_addr` = `ptr` and `wr_data` = byte.
  - `ptr` <= `ptr`+1, mod 16 (15 wraps to 0).
  - ACK, then return to WDATA.
- **RDATA.** On each SCL fall, `sda_oe` = ~bit, for 8 bits. After the 8th bit, release SDA and go to RDATA_MACK.
- **RDATA_MACK.** Sample SDA on the next SCL rise.
  - 0 (ACK): `ptr`++ mod 16, load the next byte, return to RDATA.
  - 1 (NACK): go to WAIT_STOP.
- **WAIT_STOP.** `sda_oe` = 0. Wait for STOP or START.
- **Bus events override any state:**
  - START (repeated start) -> ADDR. `ptr` is preserved.
  - STOP -> IDLE with `sda_oe` = 0 and `busy` = 0.
  - A START/STOP mid-byte discards the partial byte; no write occurs.
- **Register file.** Not cleared by STOP. `ptr` persists across transactions.

## Timing
- **Reset values** (asynchronous, immediate on `rst` = 1; applies mid-transaction too):
  - state = IDLE, `ptr` = 0.
  - `sda_oe` = 0, `wr_valid` = 0, `wr_addr` = 0, `wr_data` = 0, `busy` = 0.
  - all registers = `RESET_FILL`.
  - synchronizers = 1 (idle bus).
- **Latency.** Pin edge to internal edge event = 3 `ref_clk` cycles. `sda_oe` updates 1 cycle after the detected SCL fall.
- **Bus speed requirement.** SCL high and low phases must each last >= 8 `ref_clk` cycles, so that `sda_oe` settles before the next SCL rise.
- **Simultaneous events.** An SCL edge and an SDA edge detected in the same cycle are treated as a data bit, not START/STOP. SDA is legal to change only while SCL is low.
- **`wr_valid`** is exactly 1 cycle wide and never asserts outside WDATA.

## Test plan
- **Write burst:** START, 0xB0, 0x03, 0xAA, 0x55, STOP.
  - Required: target ACKs all 4 bytes.
  - `wr_valid` pulses twice: (3, 0xAA) then (4, 0x55).
  - `dbg_data` at 3 = 0xAA and at 4 = 0x55.
  - `busy` ends low.
- **Combined read:** START, 0xB0, 0x03, repeated START, 0xB1, read 2 bytes (master ACK then NACK), STOP.
  - Required: SDA carries 0xAA then 0x55.
  - `sda_oe` = 0 after the NACK.
- **Address mismatch:** START, 0xA0, 0x01, STOP.
  - Required: no ACK (SDA high on the 9th clock) and no `wr_valid`.
  - `busy` stays 0.
- **Pointer wrap:** write to pointer 0x0F with data 0x11, 0x22.
  - Required: reg15 = 0x11 and reg0 = 0x22.
  - `wr_addr` sequence is 15, 0.
- **Aborts:** STOP after 4 data bits, and separately `rst` pulsed mid-WDATA.
  - Required: no write occurs; `sda_oe` = 0.
  - After `rst`, all registers = `RESET_FILL` and `ptr` = 0.
- **Loopback:** drive with the team's `i2c` initiator at its default clock divider.
  - Required: every byte the initiator sends is ACKed and appears on `wr_data`.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target: oversamples SCL/SDA on ref_clk, matches a 7-bit address and
// serves a 16x8 register file through an auto-incrementing pointer.
module i2c_target #(
  parameter logic [6:0] ADDR       = 7'h58,
  parameter logic [7:0] RESET_FILL = 8'h00
) (
  input  logic       ref_clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [3:0] dbg_addr,
  output logic [7:0] dbg_data
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_MACK, ST_WAIT_STOP
  } state_t;

  logic [1:0] scl_sync_r, sda_sync_r;
  logic       scl_prev_r, sda_prev_r;
  logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t     state_r, state_n;
  logic [3:0] cnt_r, cnt_n;
  logic [6:0] shift_r, shift_n;
  logic [7:0] rd_shift_r, rd_shift_n;
  logic [3:0] ptr_r, ptr_n, ptr_inc_s;
  logic       rw_r, rw_n;
  logic       ack_phase_r, ack_phase_n;
  logic       sda_oe_r, sda_oe_n;
  logic       busy_r, busy_n;
  logic       we_s;
  logic [7:0] byte_s, rd_sel_s, rd_next_s;
  logic       wr_valid_r;
  logic [3:0] wr_addr_r;
  logic [7:0] wr_data_r;
  logic [7:0] regs_r [16];

  // Two-flop synchronizers plus previous-value copy; idle bus is high.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
      scl_prev_r <= scl_sync_r[1];
      sda_prev_r <= sda_sync_r[1];
    end
  end

  assign scl_s      = scl_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  // SCL must be stably high, so a coincident SCL edge makes it a data bit.
  assign start_s    = ~sda_s & sda_prev_r & scl_s & scl_prev_r;
  assign stop_s     = sda_s & ~sda_prev_r & scl_s & scl_prev_r;
  assign byte_s     = {shift_r, sda_s};
  assign ptr_inc_s  = ptr_r + 4'd1;
  assign rd_sel_s   = regs_r[ptr_r];
  assign rd_next_s  = regs_r[ptr_inc_s];

  // Next-state and datapath decode; bus events take priority over any state.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    shift_n     = shift_r;
    rd_shift_n  = rd_shift_r;
    ptr_n       = ptr_r;
    rw_n        = rw_r;
    ack_phase_n = ack_phase_r;
    sda_oe_n    = sda_oe_r;
    busy_n      = busy_r;
    we_s        = 1'b0;
    if (stop_s) begin
      state_n     = ST_IDLE;
      cnt_n       = 4'd0;
      ack_phase_n = 1'b0;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b0;
    end else if (start_s) begin
      state_n     = ST_ADDR;
      cnt_n       = 4'd0;
      ack_phase_n = 1'b0;
      sda_oe_n    = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: sda_oe_n = 1'b0;
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_s) begin
            shift_n = byte_s[6:0];
            cnt_n   = cnt_r + 4'd1;
            if (cnt_r == 4'd7) begin
              cnt_n       = 4'd0;
              ack_phase_n = 1'b0;
              case (state_r)
                ST_ADDR: begin
                  if (byte_s[7:1] == ADDR) begin
                    state_n = ST_ADDR_ACK;
                    busy_n  = 1'b1;
                    rw_n    = byte_s[0];
                  end else begin
                    state_n  = ST_WAIT_STOP;
                    sda_oe_n = 1'b0;
                  end
                end
                ST_PTR: begin
                  ptr_n   = byte_s[3:0];
                  state_n = ST_PTR_ACK;
                end
                ST_WDATA: begin
                  we_s    = 1'b1;
                  ptr_n   = ptr_inc_s;
                  state_n = ST_WDATA_ACK;
                end
                default: state_n = ST_IDLE;
              endcase
            end else begin
              state_n = state_r;
            end
          end else begin
            shift_n = shift_r;
          end
        end
        // First fall after the byte starts the ACK, the next fall ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_s) begin
            if (!ack_phase_r) begin
              sda_oe_n    = 1'b1;
              ack_phase_n = 1'b1;
            end else begin
              sda_oe_n    = 1'b0;
              ack_phase_n = 1'b0;
              cnt_n       = 4'd0;
              if (state_r == ST_ADDR_ACK && rw_r) begin
                state_n    = ST_RDATA;
                rd_shift_n = {rd_sel_s[6:0], 1'b0};
                sda_oe_n   = ~rd_sel_s[7];
                cnt_n      = 4'd1;
              end else if (state_r == ST_ADDR_ACK) begin
                state_n = ST_PTR;
              end else begin
                state_n = ST_WDATA;
              end
            end
          end else begin
            ack_phase_n = ack_phase_r;
          end
        end
        ST_RDATA: begin
          if (scl_fall_s) begin
            if (cnt_r == 4'd8) begin
              sda_oe_n = 1'b0;
              state_n  = ST_RDATA_MACK;
            end else begin
              sda_oe_n   = ~rd_shift_r[7];
              rd_shift_n = {rd_shift_r[6:0], 1'b0};
              cnt_n      = cnt_r + 4'd1;
            end
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_RDATA_MACK: begin
          if (scl_rise_s) begin
            if (!sda_s) begin
              ptr_n      = ptr_inc_s;
              rd_shift_n = rd_next_s;
              cnt_n      = 4'd0;
              state_n    = ST_RDATA;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end else begin
            state_n = state_r;
          end
        end
        ST_WAIT_STOP: sda_oe_n = 1'b0;
        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      shift_r     <= 7'd0;
      rd_shift_r  <= 8'd0;
      ptr_r       <= 4'd0;
      rw_r        <= 1'b0;
      ack_phase_r <= 1'b0;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      shift_r     <= shift_n;
      rd_shift_r  <= rd_shift_n;
      ptr_r       <= ptr_n;
      rw_r        <= rw_n;
      ack_phase_r <= ack_phase_n;
      sda_oe_r    <= sda_oe_n;
      busy_r      <= busy_n;
    end
  end

  // Register file and committed-write strobe.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= RESET_FILL;
      wr_valid_r <= 1'b0;
      wr_addr_r  <= 4'd0;
      wr_data_r  <= 8'd0;
    end else begin
      wr_valid_r <= we_s;
      if (we_s) begin
        regs_r[ptr_r] <= byte_s;
        wr_addr_r     <= ptr_r;
        wr_data_r     <= byte_s;
      end
    end
  end

  assign sda_oe   = sda_oe_r;
  assign wr_valid = wr_valid_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign busy     = busy_r;
  assign dbg_data = regs_r[dbg_addr];

endmodule
